// File: rtl/commit_unit_np.sv
// commit_unit_np: in-order retire stage for up to four scoreboard ports.
// Decides which head entries retire each cycle and drives the register-file
// write enables. Drives the LSU/CSR commit strobes and exception reporting.
// Holds a SYS FSM that drains pending stores before a fence retires, and
// keeps the retired-instruction counter.
//
// Handshake: valid_i[i] means "the scoreboard offers entry i this cycle";
// commit_ack_o[i] is the acceptance. The entry retires in the cycle where
// both are high, and the scoreboard then advances. Acks always form a
// contiguous run starting at port 0.
module commit_unit_np #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned TRANS_ID_BITS   = 3
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          halt_i,
    input  logic                                          single_step_i,
    input  logic [NR_COMMIT_PORTS-1:0]                    valid_i,
    input  logic [NR_COMMIT_PORTS-1:0]                    ex_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0]                    is_fpr_i,
    input  logic [NR_COMMIT_PORTS-1:0][2:0]               fu_i,
    input  logic [NR_COMMIT_PORTS-1:0][1:0]               sys_op_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]               rd_i,
    input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]          result_i,
    input  logic [NR_COMMIT_PORTS-1:0][4:0]               fflags_i,
    input  logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_i,
    input  logic                                          lsu_ready_i,
    input  logic                                          no_st_pending_i,
    input  logic                                          csr_ex_i,
    input  logic [XLEN-1:0]                               csr_rdata_i,
    output logic [NR_COMMIT_PORTS-1:0]                    commit_ack_o,
    output logic [NR_COMMIT_PORTS-1:0]                    we_gpr_o,
    output logic [NR_COMMIT_PORTS-1:0]                    we_fpr_o,
    output logic [NR_COMMIT_PORTS-1:0][4:0]               waddr_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]          wdata_o,
    output logic                                          commit_lsu_o,
    output logic                                          commit_csr_o,
    output logic                                          fflags_we_o,
    output logic [4:0]                                    fflags_o,
    output logic                                          fence_o,
    output logic                                          fence_i_o,
    output logic                                          sfence_vma_o,
    output logic                                          exception_o,
    output logic [TRANS_ID_BITS-1:0]                      commit_trans_id_o,
    output logic                                          commit_ld_valid_o,
    output logic [XLEN-1:0]                               instret_o,
    output logic                                          sys_state_o
);

    localparam int unsigned N = NR_COMMIT_PORTS;

    localparam logic [2:0] FU_LOAD  = 3'd1;
    localparam logic [2:0] FU_STORE = 3'd2;
    localparam logic [2:0] FU_CSR   = 3'd5;
    localparam logic [2:0] FU_FPU   = 3'd6;
    localparam logic [2:0] FU_SYS   = 3'd7;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } sys_state_e;

    sys_state_e         state_q, state_d;
    logic [N-1:0]       ack, we_gpr, we_fpr;
    logic [N-1:0][XLEN-1:0] wdata;
    logic               lsu_commit, csr_commit, fflags_we, exception;
    logic               fence_p, fence_i_p, sfence_p;
    logic [4:0]         fflags;
    logic [XLEN-1:0]    instret_q, ack_count;
    logic               younger_ok, eligible, blocked, store_used;
    logic               unused_hi;

    // Ports above 0 may only retire alongside an ordinary port-0 op.
    assign younger_ok = !single_step_i && (fu_i[0] != FU_CSR) && (fu_i[0] != FU_SYS);

    // Only port 0's SYS op and trans-id matter; the others are ignored.
    assign unused_hi = ^{sys_op_i, trans_id_i};

    // Ack selection and SYS FSM next state: in-order, one store per cycle.
    always_comb begin
        state_d    = state_q;
        ack        = '0;
        lsu_commit = 1'b0;
        fence_p    = 1'b0;
        fence_i_p  = 1'b0;
        sfence_p   = 1'b0;
        eligible   = 1'b0;
        blocked    = 1'b0;
        store_used = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i[0] && !ex_valid_i[0] && !halt_i && fu_i[0] == FU_SYS) begin
                    // Hold the SYS op until stores have drained.
                    state_d = S_DRAIN;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        eligible = valid_i[i] && !ex_valid_i[i] && !halt_i;
                        if (i != 0)
                            eligible = eligible && younger_ok &&
                                       (fu_i[i] != FU_CSR) && (fu_i[i] != FU_SYS);
                        if (fu_i[i] == FU_CSR && csr_ex_i)
                            eligible = 1'b0;
                        if (fu_i[i] == FU_SYS)
                            eligible = 1'b0;
                        if (fu_i[i] == FU_STORE && (store_used || !lsu_ready_i))
                            eligible = 1'b0;
                        if (blocked || !eligible) begin
                            blocked = 1'b1;
                        end else begin
                            ack[i] = 1'b1;
                            if (fu_i[i] == FU_STORE)
                                store_used = 1'b1;
                        end
                    end
                    lsu_commit = store_used;
                end
            end
            S_DRAIN: begin
                if (!valid_i[0]) begin
                    // Entry was flushed: abandon the SYS op silently.
                    state_d = S_IDLE;
                end else if (no_st_pending_i && !halt_i && !ex_valid_i[0]) begin
                    ack[0]  = 1'b1;
                    state_d = S_IDLE;
                    case (sys_op_i[0])
                        2'd1:    fence_p   = 1'b1;
                        2'd2:    fence_i_p = 1'b1;
                        2'd3:    sfence_p  = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write-back enables, data mux, fflags accumulation and retire count.
    always_comb begin
        we_gpr    = '0;
        we_fpr    = '0;
        fflags    = '0;
        fflags_we = 1'b0;
        wdata     = result_i;
        ack_count = '0;
        for (int i = 0; i < N; i++) begin
            if (ack[i] && fu_i[i] != FU_STORE && fu_i[i] != FU_SYS) begin
                if (is_fpr_i[i])
                    we_fpr[i] = 1'b1;
                else
                    we_gpr[i] = 1'b1;
            end
            if (ack[i] && fu_i[i] == FU_FPU) begin
                fflags    = fflags | fflags_i[i];
                fflags_we = 1'b1;
            end
            ack_count = ack_count + {{(XLEN-1){1'b0}}, ack[i]};
        end
        csr_commit = ack[0] && (fu_i[0] == FU_CSR);
        if (fu_i[0] == FU_CSR)
            wdata[0] = csr_rdata_i;
        exception = valid_i[0] && !halt_i &&
                    (ex_valid_i[0] || (fu_i[0] == FU_CSR && csr_ex_i));
    end

    // SYS state and retired-instruction counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_q + ack_count;
        end
    end

    // Output stage: everything held at zero while reset is asserted.
    always_comb begin
        commit_ack_o      = '0;
        we_gpr_o          = '0;
        we_fpr_o          = '0;
        waddr_o           = '0;
        wdata_o           = '0;
        commit_lsu_o      = 1'b0;
        commit_csr_o      = 1'b0;
        fflags_we_o       = 1'b0;
        fflags_o          = '0;
        fence_o           = 1'b0;
        fence_i_o         = 1'b0;
        sfence_vma_o      = 1'b0;
        exception_o       = 1'b0;
        commit_trans_id_o = '0;
        commit_ld_valid_o = 1'b0;
        instret_o         = '0;
        sys_state_o       = 1'b0;
        if (!rst_i) begin
            commit_ack_o      = ack;
            we_gpr_o          = we_gpr;
            we_fpr_o          = we_fpr;
            waddr_o           = rd_i;
            wdata_o           = wdata;
            commit_lsu_o      = lsu_commit;
            commit_csr_o      = csr_commit;
            fflags_we_o       = fflags_we;
            fflags_o          = fflags;
            fence_o           = fence_p;
            fence_i_o         = fence_i_p;
            sfence_vma_o      = sfence_p;
            exception_o       = exception;
            commit_trans_id_o = trans_id_i[0];
            commit_ld_valid_o = valid_i[0] && (fu_i[0] == FU_LOAD);
            instret_o         = instret_q;
            sys_state_o       = (state_q == S_DRAIN);
        end
    end

endmodule

// File: tb/tb_commit_unit_np.sv
// Testbench for commit_unit_np with four ports and a 64-bit counter.
module tb_commit_unit_np;

  localparam int N = 4;
  localparam int X = 64;
  localparam int T = 3;
  localparam int W = 24;

  localparam logic [2:0] ALU = 3'd0, LOAD = 3'd1, STORE = 3'd2, CSR = 3'd5, FPU = 3'd6, SYS = 3'd7;

  logic                 clk = 1'b0;
  logic                 rst_i, halt_i, single_step_i;
  logic [N-1:0]         valid_i, ex_valid_i, is_fpr_i;
  logic [N-1:0][2:0]    fu_i;
  logic [N-1:0][1:0]    sys_op_i;
  logic [N-1:0][4:0]    rd_i;
  logic [N-1:0][X-1:0]  result_i;
  logic [N-1:0][4:0]    fflags_i;
  logic [N-1:0][T-1:0]  trans_id_i;
  logic                 lsu_ready_i, no_st_pending_i, csr_ex_i;
  logic [X-1:0]         csr_rdata_i;
  logic [N-1:0]         commit_ack_o, we_gpr_o, we_fpr_o;
  logic [N-1:0][4:0]    waddr_o;
  logic [N-1:0][X-1:0]  wdata_o;
  logic                 commit_lsu_o, commit_csr_o, fflags_we_o;
  logic [4:0]           fflags_o;
  logic                 fence_o, fence_i_o, sfence_vma_o, exception_o;
  logic [T-1:0]         commit_trans_id_o;
  logic                 commit_ld_valid_o;
  logic [X-1:0]         instret_o;
  logic                 sys_state_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v, got_v;
  logic [X-1:0] exp_instret;
  int checks = 0;
  int errors = 0;

  commit_unit_np #(.NR_COMMIT_PORTS(N), .XLEN(X), .TRANS_ID_BITS(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .halt_i(halt_i), .single_step_i(single_step_i),
    .valid_i(valid_i), .ex_valid_i(ex_valid_i), .is_fpr_i(is_fpr_i),
    .fu_i(fu_i), .sys_op_i(sys_op_i), .rd_i(rd_i), .result_i(result_i),
    .fflags_i(fflags_i), .trans_id_i(trans_id_i),
    .lsu_ready_i(lsu_ready_i), .no_st_pending_i(no_st_pending_i), .csr_ex_i(csr_ex_i),
    .csr_rdata_i(csr_rdata_i),
    .commit_ack_o(commit_ack_o), .we_gpr_o(we_gpr_o), .we_fpr_o(we_fpr_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o),
    .commit_lsu_o(commit_lsu_o), .commit_csr_o(commit_csr_o),
    .fflags_we_o(fflags_we_o), .fflags_o(fflags_o),
    .fence_o(fence_o), .fence_i_o(fence_i_o), .sfence_vma_o(sfence_vma_o),
    .exception_o(exception_o), .commit_trans_id_o(commit_trans_id_o),
    .commit_ld_valid_o(commit_ld_valid_o), .instret_o(instret_o),
    .sys_state_o(sys_state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // packing helpers (no checking inside)
  function automatic logic [W-1:0] mk(input logic [3:0] ack, input logic [3:0] gpr,
                                      input logic [3:0] fpr, input logic lsu, input logic csr,
                                      input logic fn, input logic fi, input logic sf,
                                      input logic ex, input logic fwe, input logic [4:0] ff);
    return {ack, gpr, fpr, lsu, csr, fn, fi, sf, ex, fwe, ff};
  endfunction

  function automatic logic [W-1:0] observe();
    return {commit_ack_o, we_gpr_o, we_fpr_o, commit_lsu_o, commit_csr_o, fence_o,
            fence_i_o, sfence_vma_o, exception_o, fflags_we_o, fflags_o};
  endfunction

  // driver tasks
  task automatic clear_inputs();
    halt_i = 1'b0; single_step_i = 1'b0;
    valid_i = '0; ex_valid_i = '0; is_fpr_i = '0;
    fu_i = '0; sys_op_i = '0; rd_i = '0; result_i = '0; fflags_i = '0; trans_id_i = '0;
    lsu_ready_i = 1'b1; no_st_pending_i = 1'b1; csr_ex_i = 1'b0; csr_rdata_i = '0;
  endtask

  task automatic set_port(input int i, input logic [2:0] fu, input logic [4:0] rd,
                          input logic [X-1:0] res);
    valid_i[i] = 1'b1; fu_i[i] = fu; rd_i[i] = rd; result_i[i] = res;
  endtask

  task automatic push(input logic [W-1:0] e);
    exp_q.push_back(e);
    exp_instret = exp_instret + X'($countones(e[W-1:W-4]));
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    set_port(0, LOAD, 5'd3, 64'h55); set_port(1, ALU, 5'd4, 64'h66);
    trans_id_i[0] = 3'd6;
    next_cycle();
    push(mk(4'b0, 4'b0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_flags got=%h exp=%h", got_v, exp_v); end
    checks++;
    if ({waddr_o, wdata_o, commit_trans_id_o, commit_ld_valid_o, instret_o, sys_state_o} !== '0) begin
      errors++; $display("FAIL reset_data got ld=%b tid=%0d instret=%0d state=%b", commit_ld_valid_o,
                         commit_trans_id_o, instret_o, sys_state_o);
    end
    exp_instret = '0;
    rst_i = 1'b0;
  endtask

  task automatic test_alu4();
    clear_inputs();
    for (int i = 0; i < N; i++) set_port(i, ALU, 5'(i + 1), 64'h100 + 64'(i));
    push(mk(4'b1111, 4'b1111, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL alu4_flags got=%h exp=%h", got_v, exp_v); end
    checks++;
    if (waddr_o !== {5'd4, 5'd3, 5'd2, 5'd1} || wdata_o[2] !== 64'h102) begin
      errors++; $display("FAIL alu4_wb got waddr=%h wdata2=%h exp waddr=%h wdata2=102", waddr_o, wdata_o[2],
                         {5'd4, 5'd3, 5'd2, 5'd1});
    end
    next_cycle();
    checks++;
    if (instret_o !== exp_instret) begin errors++; $display("FAIL alu4_instret got=%0d exp=%0d", instret_o, exp_instret); end
  endtask

  task automatic test_fpu_load();
    clear_inputs();
    set_port(0, FPU, 5'd1, 64'h1); is_fpr_i[0] = 1'b1; fflags_i[0] = 5'b00001;
    set_port(1, FPU, 5'd2, 64'h2); is_fpr_i[1] = 1'b1; fflags_i[1] = 5'b00100;
    set_port(2, ALU, 5'd3, 64'h3); fflags_i[2] = 5'b10000;
    push(mk(4'b0111, 4'b0100, 4'b0011, 0, 0, 0, 0, 0, 0, 1, 5'b00101));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL fpu_fflags got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    clear_inputs();
    set_port(0, LOAD, 5'd9, 64'h9); trans_id_i[0] = 3'd5; trans_id_i[1] = 3'd2;
    push(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL load_flags got=%h exp=%h", got_v, exp_v); end
    checks++;
    if (commit_ld_valid_o !== 1'b1 || commit_trans_id_o !== 3'd5) begin
      errors++; $display("FAIL load_tid got ld=%b tid=%0d exp ld=1 tid=5", commit_ld_valid_o, commit_trans_id_o);
    end
    next_cycle();
  endtask

  task automatic test_store();
    clear_inputs();
    set_port(0, ALU, 5'd1, 64'h1); set_port(1, STORE, 5'd2, 64'h2);
    set_port(2, STORE, 5'd3, 64'h3); set_port(3, ALU, 5'd4, 64'h4);
    push(mk(4'b0011, 4'b0001, 4'b0, 1, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL store_two got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    lsu_ready_i = 1'b0;
    push(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL store_not_ready got=%h exp=%h", got_v, exp_v); end
    next_cycle();
  endtask

  task automatic test_csr();
    clear_inputs();
    set_port(0, CSR, 5'd7, 64'hdead); set_port(1, ALU, 5'd8, 64'h8);
    csr_rdata_i = 64'hbeef;
    push(mk(4'b0001, 4'b0001, 4'b0, 0, 1, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL csr_ok got=%h exp=%h", got_v, exp_v); end
    checks++;
    if (wdata_o[0] !== 64'hbeef) begin errors++; $display("FAIL csr_wdata got=%h exp=beef", wdata_o[0]); end
    next_cycle();
    csr_ex_i = 1'b1;
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 1, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL csr_ex got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    clear_inputs();
    set_port(0, ALU, 5'd1, 64'h1); set_port(1, CSR, 5'd2, 64'h2); set_port(2, ALU, 5'd3, 64'h3);
    push(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL csr_port1 got=%h exp=%h", got_v, exp_v); end
    next_cycle();
  endtask

  task automatic test_step_halt();
    clear_inputs();
    for (int i = 0; i < N; i++) set_port(i, ALU, 5'(i + 10), 64'(i));
    single_step_i = 1'b1;
    push(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL single_step got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    single_step_i = 1'b0; halt_i = 1'b1; ex_valid_i[0] = 1'b1;
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL halt got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    checks++;
    if (instret_o !== exp_instret) begin errors++; $display("FAIL step_instret got=%0d exp=%0d", instret_o, exp_instret); end
  endtask

  task automatic test_exception();
    clear_inputs();
    for (int i = 0; i < N; i++) set_port(i, ALU, 5'(i + 1), 64'(i));
    ex_valid_i[1] = 1'b1;
    push(mk(4'b0001, 4'b0001, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ex_port1 got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    clear_inputs();
    for (int i = 0; i < N - 1; i++) set_port(i, ALU, 5'(i + 2), 64'(i));
    ex_valid_i[0] = 1'b1;
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 1, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ex_port0 got=%h exp=%h", got_v, exp_v); end
    next_cycle();
  endtask

  task automatic test_fence_i();
    clear_inputs();
    set_port(0, SYS, 5'd0, 64'h0); sys_op_i[0] = 2'd2; set_port(1, ALU, 5'd5, 64'h5);
    no_st_pending_i = 1'b0;
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v || sys_state_o !== 1'b0) begin
      errors++; $display("FAIL fence_i_enter got=%h state=%b exp=%h state=0", got_v, sys_state_o, exp_v);
    end
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
      settle();
      exp_v = exp_q.pop_front(); got_v = observe(); checks++;
      if (got_v !== exp_v || sys_state_o !== 1'b1) begin
        errors++; $display("FAIL fence_i_drain%0d got=%h state=%b exp=%h state=1", c, got_v, sys_state_o, exp_v);
      end
      next_cycle();
    end
    no_st_pending_i = 1'b1;
    push(mk(4'b0001, 4'b0000, 4'b0, 0, 0, 0, 1, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL fence_i_retire got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    clear_inputs();
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v || sys_state_o !== 1'b0) begin
      errors++; $display("FAIL fence_i_after got=%h state=%b exp=%h state=0", got_v, sys_state_o, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_fence_sfence_flush();
    for (int k = 1; k <= 3; k += 2) begin
      clear_inputs();
      set_port(0, SYS, 5'd0, 64'h0); sys_op_i[0] = 2'(k);
      push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
      settle();
      exp_v = exp_q.pop_front(); got_v = observe(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL sys%0d_idle got=%h exp=%h", k, got_v, exp_v); end
      next_cycle();
      push(mk(4'b0001, 4'b0000, 4'b0, 0, 0, k == 1, 0, k == 3, 0, 0, 5'b0));
      settle();
      exp_v = exp_q.pop_front(); got_v = observe(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL sys%0d_retire got=%h exp=%h", k, got_v, exp_v); end
      next_cycle();
    end
    clear_inputs();
    set_port(0, SYS, 5'd0, 64'h0); sys_op_i[0] = 2'd1; halt_i = 1'b0;
    next_cycle();
    halt_i = 1'b1;
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v || sys_state_o !== 1'b1) begin
      errors++; $display("FAIL sys_halt got=%h state=%b exp=%h state=1", got_v, sys_state_o, exp_v);
    end
    next_cycle();
    halt_i = 1'b0; valid_i[0] = 1'b0;
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL sys_flush got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    checks++;
    if (sys_state_o !== 1'b0) begin errors++; $display("FAIL sys_flush_state got=%b exp=0", sys_state_o); end
  endtask

  task automatic test_instret_wrap();
    clear_inputs();
    force dut.instret_q = {X{1'b1}};
    #1 release dut.instret_q;
    checks++;
    if (instret_o !== {X{1'b1}}) begin errors++; $display("FAIL wrap_preload got=%h exp=all ones", instret_o); end
    set_port(0, ALU, 5'd1, 64'h1); set_port(1, ALU, 5'd2, 64'h2);
    exp_instret = {X{1'b1}};
    push(mk(4'b0011, 4'b0011, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL wrap_ack got=%h exp=%h", got_v, exp_v); end
    @(posedge clk); #1;
    checks++;
    if (instret_o !== 64'd1 || exp_instret !== 64'd1) begin
      errors++; $display("FAIL wrap_instret got=%0d exp=1", instret_o);
    end
  endtask

  task automatic test_reset_drain();
    clear_inputs();
    set_port(0, SYS, 5'd0, 64'h0); sys_op_i[0] = 2'd1; no_st_pending_i = 1'b0;
    next_cycle();
    checks++;
    if (sys_state_o !== 1'b1) begin errors++; $display("FAIL rdrain_enter got=%b exp=1", sys_state_o); end
    rst_i = 1'b1; no_st_pending_i = 1'b1;
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rdrain_during got=%h exp=%h", got_v, exp_v); end
    next_cycle();
    exp_instret = '0;
    rst_i = 1'b0;
    push(mk(4'b0000, 4'b0000, 4'b0, 0, 0, 0, 0, 0, 0, 0, 5'b0));
    settle();
    exp_v = exp_q.pop_front(); got_v = observe(); checks++;
    if (got_v !== exp_v || sys_state_o !== 1'b0 || instret_o !== exp_instret) begin
      errors++; $display("FAIL rdrain_after got=%h state=%b instret=%0d exp=%h state=0 instret=0",
                         got_v, sys_state_o, instret_o, exp_v);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] v, e, a;
    logic run;
    clear_inputs();
    for (int n = 0; n < 40; n++) begin
      v = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      for (int i = 0; i < N; i++) begin
        fu_i[i] = ALU; rd_i[i] = 5'($urandom_range(0, 31)); result_i[i] = 64'($urandom);
      end
      valid_i = v; ex_valid_i = e;
      run = 1'b1; a = '0;
      for (int i = 0; i < N; i++) begin
        if (run && v[i] && !e[i]) a[i] = 1'b1;
        else run = 1'b0;
      end
      push(mk(a, a, 4'b0, 0, 0, 0, 0, 0, v[0] & e[0], 0, 5'b0));
      settle();
      exp_v = exp_q.pop_front(); got_v = observe(); checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL b2b_%0d v=%b e=%b got=%h exp=%h", n, v, e, got_v, exp_v);
      end
      next_cycle();
    end
    checks++;
    if (instret_o !== exp_instret) begin errors++; $display("FAIL b2b_instret got=%0d exp=%0d", instret_o, exp_instret); end
  endtask

  // sequence and final report
  initial begin
    exp_instret = '0;
    test_reset();
    test_alu4();
    test_fpu_load();
    test_store();
    test_csr();
    test_step_halt();
    test_exception();
    test_fence_i();
    test_fence_sfence_flush();
    test_instret_wrap();
    test_reset_drain();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_left got=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
